alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One transaction in flight: IDLE (arbitrate/latch) -> EXEC (capture) -> RESP (hold).
module alu_arbiter #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*DW-1:0] req_opA,
  input  logic [2*DW-1:0] req_opB,
  input  logic [5:0]      req_sel,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [DW-1:0]   rsp_res,
  output logic [2:0]      rsp_flags,
  output logic            rsp_err,
  output logic [DW-1:0]   alu_opA,
  output logic [DW-1:0]   alu_opB,
  output logic [2:0]      alu_sel,
  input  logic [DW-1:0]   alu_res,
  input  logic [2:0]      alu_flags,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [2:0]    sel_q, sel_d;
  logic [DW-1:0] res_q, res_d;
  logic [2:0]    flags_q, flags_d;
  logic          err_q, err_d;
  logic          arb_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      opa_q   <= '0;
      opb_q   <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sel_d     = sel_q;
    res_d     = res_q;
    flags_d   = flags_q;
    err_d     = err_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    // On a tie the requester not served last wins; a lone requester always wins.
    arb_g     = (req_valid == 2'b11) ? ~last_q : req_valid[1];

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[arb_g] = 1'b1;
          gnt_d   = arb_g;
          opa_d   = arb_g ? req_opA[2*DW-1:DW] : req_opA[DW-1:0];
          opb_d   = arb_g ? req_opB[2*DW-1:DW] : req_opB[DW-1:0];
          sel_d   = arb_g ? req_sel[5:3] : req_sel[2:0];
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Selects 101..111 have no ALU meaning; answer with an error instead.
        if (sel_q > 3'd4) begin
          res_d   = '0;
          flags_d = 3'b000;
          err_d   = 1'b1;
        end else begin
          res_d   = alu_res;
          flags_d = alu_flags;
          err_d   = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_opA   = opa_q;
  assign alu_opB   = opb_q;
  assign alu_sel   = sel_q;
  assign rsp_res   = res_q;
  assign rsp_flags = flags_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE);

endmodule
